// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution, BTB write and fetch redirect
//
// Compares the outcome fetch predicted with the actual outcome of the
// instruction in EX. It produces a registered BTB write and a registered
// one-cycle fetch redirect on mispredict. After each redirect, it ignores EX
// for SQUASH_CYCLES cycles so that wrong-path instructions still in flight
// cannot resolve.
//
// Optional feature macro: BRU_PERF_CNT_EN (adds perf_ctrl_cnt / perf_mispred_cnt).
//
// Parameters:
//   XLEN           address/data width
//   SQUASH_CYCLES  length of the post-redirect squash window, 1..15
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ex_valid              EX holds a valid resolving instruction
//   ex_pc                 PC of the EX instruction
//   ex_is_branch          conditional branch
//   ex_is_jump            JAL/JALR
//   ex_taken              actual direction (1 for jumps)
//   ex_target             actual taken target
//   pred_taken            fetch predicted taken
//   pred_target           target fetch used when pred_taken=1
//   btb_update_en         BTB write strobe
//   btb_pc_update         PC to write
//   btb_target_actual     target to write
//   btb_is_branch_or_jmp  qualifier for the BTB write
//   redirect_valid        one-cycle fetch redirect pulse
//   redirect_pc           corrected fetch PC
//   squash_active         squash window active
//   perf_ctrl_cnt         (BRU_PERF_CNT_EN) accepted control instructions
//   perf_mispred_cnt      (BRU_PERF_CNT_EN) accepted mispredicts

module branch_resolve_unit #(
  parameter int XLEN          = 32,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            btb_update_en,
  output logic [XLEN-1:0] btb_pc_update,
  output logic [XLEN-1:0] btb_target_actual,
  output logic            btb_is_branch_or_jmp,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            squash_active
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_ctrl_cnt,
  output logic [31:0]     perf_mispred_cnt
`endif
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  state_t          state, state_n;
  logic [3:0]      sq_cnt, sq_cnt_n;

  logic            ctrl;
  logic            accept;
  logic            mispredict;
  logic [XLEN-1:0] fallthrough;
  logic [XLEN-1:0] correct_pc;

  logic            btb_en_n;
  logic [XLEN-1:0] btb_pc_n;
  logic [XLEN-1:0] btb_tgt_n;
  logic            btb_bj_n;
  logic            redir_n;
  logic [XLEN-1:0] redir_pc_n;

  // Resolution datapath. The fallthrough add wraps naturally at XLEN bits.
  always_comb begin
    ctrl        = ex_is_branch | ex_is_jump;
    accept      = ex_valid & (state == RUN);
    fallthrough = ex_pc + XLEN'(4);
    correct_pc  = (ctrl & ex_taken) ? ex_target : fallthrough;

    mispredict = 1'b0;
    if (ctrl) begin
      mispredict = (pred_taken != ex_taken) |
                   (pred_taken & ex_taken & (pred_target != ex_target));
    end else begin
      // A predicted-taken non-control instruction is a BTB alias hit;
      // fetch went the wrong way and must return to the fallthrough.
      mispredict = pred_taken;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    sq_cnt_n   = sq_cnt;
    btb_en_n   = 1'b0;
    btb_pc_n   = btb_pc_update;
    btb_tgt_n  = btb_target_actual;
    btb_bj_n   = btb_is_branch_or_jmp;
    redir_n    = 1'b0;
    redir_pc_n = redirect_pc;

    case (state)
      RUN: begin
        if (accept & mispredict) begin
          state_n  = SQUASH;
          sq_cnt_n = SQ_LOAD;
        end
      end
      SQUASH: begin
        // The counter==1 cycle is the last squash cycle.
        sq_cnt_n = sq_cnt - 4'd1;
        if (sq_cnt == 4'd1) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n  = RUN;
        sq_cnt_n = 4'd0;
      end
    endcase

    // Taken control instructions always refresh the BTB, whether or not
    // they mispredicted, so a wrong-target entry is corrected.
    if (accept & ctrl & ex_taken) begin
      btb_en_n  = 1'b1;
      btb_pc_n  = ex_pc;
      btb_tgt_n = ex_target;
      btb_bj_n  = 1'b1;
    end

    if (accept & mispredict) begin
      redir_n    = 1'b1;
      redir_pc_n = correct_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= RUN;
      sq_cnt               <= 4'd0;
      btb_update_en        <= 1'b0;
      btb_pc_update        <= '0;
      btb_target_actual    <= '0;
      btb_is_branch_or_jmp <= 1'b0;
      redirect_valid       <= 1'b0;
      redirect_pc          <= '0;
    end else begin
      state                <= state_n;
      sq_cnt               <= sq_cnt_n;
      btb_update_en        <= btb_en_n;
      btb_pc_update        <= btb_pc_n;
      btb_target_actual    <= btb_tgt_n;
      btb_is_branch_or_jmp <= btb_bj_n;
      redirect_valid       <= redir_n;
      redirect_pc          <= redir_pc_n;
    end
  end

  // The state register itself is the squash flag, so it rises with the
  // redirect pulse and drops after SQUASH_CYCLES cycles.
  assign squash_active = (state == SQUASH);

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ctrl_cnt    <= 32'd0;
      perf_mispred_cnt <= 32'd0;
    end else begin
      if (accept & ctrl) begin
        perf_ctrl_cnt <= perf_ctrl_cnt + 32'd1;
      end
      if (accept & mispredict) begin
        perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        btb_update_en;
  logic [31:0] btb_pc_update;
  logic [31:0] btb_target_actual;
  logic        btb_is_branch_or_jmp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        squash_active;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_ctrl_cnt;
  logic [31:0] perf_mispred_cnt;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .SQUASH_CYCLES(2)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ex_valid             (ex_valid),
    .ex_pc                (ex_pc),
    .ex_is_branch         (ex_is_branch),
    .ex_is_jump           (ex_is_jump),
    .ex_taken             (ex_taken),
    .ex_target            (ex_target),
    .pred_taken           (pred_taken),
    .pred_target          (pred_target),
    .btb_update_en        (btb_update_en),
    .btb_pc_update        (btb_pc_update),
    .btb_target_actual    (btb_target_actual),
    .btb_is_branch_or_jmp (btb_is_branch_or_jmp),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .squash_active        (squash_active)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_ctrl_cnt        (perf_ctrl_cnt),
    .perf_mispred_cnt     (perf_mispred_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] pc;
    logic        br;
    logic        j;
    logic        tk;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptg;
  } stim_t;

  typedef struct {
    logic        all;
    logic        be;
    logic [31:0] bpc;
    logic [31:0] btg;
    logic        rv;
    logic [31:0] rpc;
    logic        sq;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_list[$];
  exp_t  sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic v, input logic [31:0] pc,
                     input logic br, input logic j, input logic tk,
                     input logic [31:0] tgt, input logic pt, input logic [31:0] ptg,
                     input logic be, input logic rv, input logic [31:0] rpc,
                     input logic sq);
    stim_t s;
    exp_t  e;
    s.rst = rst; s.v = v; s.pc = pc; s.br = br; s.j = j; s.tk = tk;
    s.tgt = tgt; s.pt = pt; s.ptg = ptg;
    e.all = rst; e.be = be; e.bpc = be ? pc : 32'h0; e.btg = be ? tgt : 32'h0;
    e.rv = rv; e.rpc = rv ? rpc : 32'h0; e.sq = sq;
    stim_q.push_back(s);
    exp_list.push_back(e);
  endtask

  // Monitor: one expected record per sampled cycle; payloads are checked
  // whenever the DUT presents a BTB write or a redirect.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("squash_active", 32'(squash_active), 32'(e.sq));
        chk("btb_update_en", 32'(btb_update_en), 32'(e.be));
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        if (btb_update_en || e.all) begin
          chk("btb_pc_update", btb_pc_update, e.bpc);
          chk("btb_target_actual", btb_target_actual, e.btg);
          chk("btb_is_branch_or_jmp", 32'(btb_is_branch_or_jmp), 32'(e.be));
        end
        if (redirect_valid || e.all) begin
          chk("redirect_pc", redirect_pc, e.rpc);
        end
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_is_branch = 1'b0;
    ex_is_jump = 1'b0; ex_taken = 1'b0; ex_target = '0;
    pred_taken = 1'b0; pred_target = '0;

    //   rst v  pc            br j  tk tgt           pt ptg           be rv rpc           sq
    add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 32'h100,      1, 0, 1, 32'h200,      1, 32'h200,      1, 0, 32'h0,        0);
    add(0, 1, 32'h104,      0, 1, 1, 32'h400,      1, 32'h400,      1, 0, 32'h0,        0);
    add(0, 1, 32'h108,      1, 0, 0, 32'h900,      0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 32'h10C,      0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 32'h100,      1, 0, 0, 32'h200,      1, 32'h200,      0, 1, 32'h104,      1);
    add(0, 1, 32'h500,      1, 0, 1, 32'h600,      0, 32'h0,        0, 0, 32'h0,        1);
    add(0, 1, 32'h504,      0, 1, 1, 32'h700,      0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 32'h40,       0, 1, 1, 32'h300,      1, 32'h280,      1, 1, 32'h300,      1);
    add(0, 1, 32'h900,      1, 0, 1, 32'h910,      1, 32'h910,      0, 0, 32'h0,        1);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h0,        1, 32'h1234,     0, 1, 32'h0,        1);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 32'h800,      1, 0, 1, 32'h880,      0, 32'h0,        1, 1, 32'h880,      1);
    add(1, 1, 32'h804,      1, 0, 1, 32'h990,      0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 32'h120,      1, 0, 1, 32'h220,      1, 32'h220,      1, 0, 32'h0,        0);
    add(0, 1, 32'h130,      1, 0, 1, 32'h30,       0, 32'h0,        1, 1, 32'h30,       1);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 1, 32'hFFFFFFFC, 1, 0, 0, 32'h10,       1, 32'h10,       0, 1, 32'h0,        1);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);

    for (int i = 0; i < stim_q.size(); i++) begin
      @(negedge clk);
      s = stim_q[i];
      reset = s.rst; ex_valid = s.v; ex_pc = s.pc; ex_is_branch = s.br;
      ex_is_jump = s.j; ex_taken = s.tk; ex_target = s.tgt;
      pred_taken = s.pt; pred_target = s.ptg;
      sb_q.push_back(exp_list[i]);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
`ifdef BRU_PERF_CNT_EN
    // Since the mid-squash reset: branches at 0x120, 0x130, 0xFFFFFFFC are
    // control; 0x130 and 0xFFFFFFFC mispredicted.
    chk("perf_ctrl_cnt", perf_ctrl_cnt, 32'd3);
    chk("perf_mispred_cnt", perf_mispred_cnt, 32'd2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
